// File: rtl/tt_pkg.sv
// tt_capture shared types.
// FSM state encoding and settle timer width.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/tt_if.sv
// Sweep control and observed-block bundle.
// master drives start/abort/F; slave is tt_capture.
interface tt_if #(
  parameter int N_IN = 3
);

  logic                 start;
  logic                 abort;
  logic                 F;
  logic [N_IN-1:0]      stim;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2**N_IN-1:0]   table_q;
  logic [N_IN-1:0]      fail_idx;

  modport master (
    output start, abort, F,
    input  stim, busy, done, pass,
    input  table_q, fail_idx
  );

  modport slave (
    input  start, abort, F,
    output stim, busy, done, pass,
    output table_q, fail_idx
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter, reloaded per vector.
// o_expired is high while the count sits at zero.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_count,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_count;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/tt_capture.sv
// Truth-table reader: sweeps stim, samples F,
// compares the table against EXPECTED.
module tt_capture
  import tt_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hEA
) (
  input logic clk,
  input logic rst,
  tt_if.slave bus
);

  localparam int TW = 2**N_IN;
  localparam logic [N_IN-1:0] K_LAST = N_IN'(TW - 1);
  // HOLD lasts SETTLE cycles: load SETTLE-1, leave at zero
  localparam logic [SETTLE_W-1:0] LD =
    (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;
  localparam state_t ST_VEC =
    (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

  state_t            r_state;
  state_t            w_next;
  logic [N_IN-1:0]   r_k;
  logic [TW-1:0]     r_table;
  logic              r_pass;
  logic [N_IN-1:0]   r_fail;
  logic [TW-1:0]     w_table_smp;
  logic [TW-1:0]     w_diff;
  logic [N_IN-1:0]   w_idx;
  logic              w_load;
  logic              w_expired;
  logic              w_go;
  logic              w_last;

  assign w_go   = bus.start & ~bus.abort;
  assign w_last = (r_k == K_LAST);

  tt_settle_timer #(
    .W (SETTLE_W)
  ) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_count   (LD),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_next = ST_VEC;
          w_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.abort)      w_next = ST_IDLE;
        else if (w_expired) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          w_next = ST_IDLE;
        end else if (w_last) begin
          w_next = ST_FINISH;
        end else begin
          w_next = ST_VEC;
          w_load = 1'b1;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_table_smp      = r_table;
    w_table_smp[r_k] = bus.F;
  end

  assign w_diff = w_table_smp ^ EXPECTED;

  // lowest mismatching index wins
  always_comb begin
    w_idx = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (w_diff[i]) w_idx = N_IN'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_table <= '0;
      r_pass  <= 1'b0;
      r_fail  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_k     <= '0;
            r_table <= '0;
            r_pass  <= 1'b0;
            r_fail  <= '0;
          end
        end
        ST_HOLD: begin
          if (bus.abort) begin
            r_k    <= '0;
            r_pass <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            r_k    <= '0;
            r_pass <= 1'b0;
          end else begin
            r_table <= w_table_smp;
            if (w_last) begin
              r_pass <= (w_diff == '0);
              r_fail <= w_idx;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stim     = r_k;
  assign bus.busy     = (r_state == ST_HOLD) ||
                        (r_state == ST_SAMPLE);
  assign bus.done     = (r_state == ST_FINISH);
  assign bus.pass     = r_pass;
  assign bus.table_q  = r_table;
  assign bus.fail_idx = r_fail;

endmodule

// File: tb/tb_tt_capture.sv
// Randomized self-check of tt_capture against a
// truth-table model, SETTLE=2 and SETTLE=0 builds.
module tb_tt_capture;

  localparam int NV = 8;
  localparam int S0 = 2;
  localparam logic [7:0] EXP = 8'hEA;
  localparam int DONE0 = 1 + NV * (S0 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] g_tt = EXP;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tt_if #(.N_IN(3)) bus0 ();
  tt_if #(.N_IN(3)) bus1 ();

  assign bus0.F = g_tt[bus0.stim];
  assign bus1.F = g_tt[bus1.stim];

  tt_capture #(
    .N_IN(3), .SETTLE(S0), .EXPECTED(EXP)
  ) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  tt_capture #(
    .N_IN(3), .SETTLE(0), .EXPECTED(EXP)
  ) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tt_of(input int m);
    logic [7:0] t;
    logic x, y, z;
    t = '0;
    for (int v = 0; v < NV; v++) begin
      x = v[2]; y = v[1]; z = v[0];
      case (m)
        0:       t[v] = (x & y) | z;
        default: t[v] = x & y;
      endcase
    end
    return t;
  endfunction

  function automatic int fidx(input logic [7:0] t);
    for (int k = 0; k < NV; k++)
      if (t[k] != EXP[k]) return k;
    return 0;
  endfunction

  task automatic wait_stim(input int v);
    for (int i = 0; i < 60; i++) begin
      if (bus0.stim == 3'(v)) break;
      tick();
    end
    chk("wait_stim", bus0.stim, v);
  endtask

  // rs: re-pulse start when vector 5 is on stim
  task automatic sweep(input logic [7:0] tt,
                       input bit rs);
    int d0c, d1c, nd0, nd1;
    int bbad, sbad;
    bit pulsed;
    d0c = 0; d1c = 0; nd0 = 0; nd1 = 0;
    bbad = 0; sbad = 0; pulsed = 0;
    g_tt = tt;
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus0.done) begin d0c = c; nd0++; end
      if (bus1.done) begin d1c = c; nd1++; end
      if (bus0.busy != (c < DONE0)) bbad++;
      if (c < DONE0 && int'(bus0.stim) != (c - 1) / (S0 + 1))
        sbad++;
      bus0.start = 1'b0;
      if (rs && !pulsed && bus0.stim == 3'd5) begin
        bus0.start = 1'b1;
        pulsed = 1'b1;
      end
      tick();
    end
    chk("done0_cyc", d0c, DONE0);
    chk("done0_cnt", nd0, 1);
    chk("busy0_win", bbad, 0);
    chk("stim0_walk", sbad, 0);
    chk("table0", bus0.table_q, tt);
    chk("pass0", bus0.pass, tt == EXP);
    chk("fidx0", bus0.fail_idx, fidx(tt));
    chk("done1_cnt", nd1, 1);
    chk("table1", bus1.table_q, tt);
    chk("pass1", bus1.pass, tt == EXP);
    if (rs) chk("restart_seen", pulsed, 1);
  endtask

  initial begin
    logic [7:0] t;
    int act;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_stim", bus0.stim, 0);
    chk("rst_table", bus0.table_q, 0);
    chk("rst_pass", bus0.pass, 0);

    sweep(tt_of(0), 1'b0);
    sweep(tt_of(1), 1'b0);
    sweep(tt_of(0), 1'b1);

    for (int i = 0; i < 6; i++) begin
      t = 8'($urandom);
      if (i == 0) t = EXP ^ 8'(1 << $urandom_range(7, 0));
      sweep(t, 1'b0);
    end

    // abort while vector 3 is held
    g_tt = EXP;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_stim(3);
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    chk("abort_busy", bus0.busy, 0);
    chk("abort_stim", bus0.stim, 0);
    act = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus0.done || bus0.busy) act++;
      tick();
    end
    chk("abort_quiet", act, 0);
    chk("abort_pass", bus0.pass, 0);
    chk("abort_part", bus0.table_q, EXP & 8'h07);
    sweep(EXP, 1'b0);

    // reset during HOLD of vector 6
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_stim(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", bus0.busy, 0);
    chk("mrst_done", bus0.done, 0);
    chk("mrst_stim", bus0.stim, 0);
    chk("mrst_pass", bus0.pass, 0);
    chk("mrst_table", bus0.table_q, 0);
    chk("mrst_fidx", bus0.fail_idx, 0);

    // start and abort together in IDLE
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.done || bus0.busy) act++;
      tick();
    end
    chk("sa_idle", act, 0);
    chk("sa_stim", bus0.stim, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
